axi_slave_req_arbiter: RTL and testbench

- Sits downstream of the AXI slave push FSMs and their request FIFOs: AR (read requests), AW (write requests) and W (write data).
- Round-robin arbitrates between the AR and AW FIFOs and pops exactly one request header at a time.
- Presents that header to the TLP builder over a valid/ready handshake.
- For writes, then streams the AWLEN+1 W beats on a separate valid/ready data channel before granting again.

---
 rtl/axi_slave_req_arbiter_if.sv | 72 +++++++
 rtl/axi_slave_req_arbiter.sv | 145 ++++++++++++++
 tb/tb_axi_slave_req_arbiter.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_slave_req_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : axi_slave_req_arbiter_if
//  Description : Bundles the signals around the request arbiter: the AR, AW
//                and W FIFO read ports, and the header and write-data
//                valid/ready channels toward the TLP builder.
//                master = arbiter side, slave = FIFOs plus TLP builder side.
//  Revision    : 1.0  initial release
// ============================================================================
interface axi_slave_req_arbiter_if #(
    parameter int ENTRY_WIDTH = 85,
    parameter int DATA_WIDTH  = 1024
);
    // AR request FIFO read port (first-word-fall-through)
    logic                   ar_empty;
    logic [ENTRY_WIDTH-1:0] ar_rd_data;
    logic                   ar_rd_en;

    // AW request FIFO read port (first-word-fall-through)
    logic                   aw_empty;
    logic [ENTRY_WIDTH-1:0] aw_rd_data;
    logic                   aw_rd_en;

    // W data FIFO read port (first-word-fall-through)
    logic                   w_empty;
    logic [DATA_WIDTH-1:0]  w_rd_data;
    logic                   w_rd_en;

    // Header channel toward the TLP builder
    logic                   hdr_valid;
    logic                   hdr_ready;
    logic                   hdr_is_wr;
    logic [ENTRY_WIDTH-1:0] hdr_data;

    // Write-data channel toward the TLP builder
    logic                   dat_valid;
    logic                   dat_ready;
    logic [DATA_WIDTH-1:0]  dat_data;
    logic                   dat_last;

    // Status
    logic                   busy;

    modport master (
        input  ar_empty, ar_rd_data,
        output ar_rd_en,
        input  aw_empty, aw_rd_data,
        output aw_rd_en,
        input  w_empty,  w_rd_data,
        output w_rd_en,
        output hdr_valid, hdr_is_wr, hdr_data,
        input  hdr_ready,
        output dat_valid, dat_data, dat_last,
        input  dat_ready,
        output busy
    );

    modport slave (
        output ar_empty, ar_rd_data,
        input  ar_rd_en,
        output aw_empty, aw_rd_data,
        input  aw_rd_en,
        output w_empty,  w_rd_data,
        input  w_rd_en,
        input  hdr_valid, hdr_is_wr, hdr_data,
        output hdr_ready,
        input  dat_valid, dat_data, dat_last,
        output dat_ready,
        input  busy
    );
endinterface
`default_nettype wire

// File: rtl/axi_slave_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : axi_slave_req_arbiter
//  Description : Round-robin arbiter between the AR and AW request FIFOs.
//                It pops one header at a time and presents it on a
//                valid/ready header channel. For writes it then streams the
//                AWLEN+1 W beats on a valid/ready data channel before the
//                next grant.
//  Revision    : 1.0  initial release
// ============================================================================
module axi_slave_req_arbiter #(
    parameter int ENTRY_WIDTH = 85,
    parameter int LEN_LSB     = 8,
    parameter int LEN_WIDTH   = 8,
    parameter int DATA_WIDTH  = 1024
) (
    input  wire logic             axi_clk,
    input  wire logic             ARESTn,
    axi_slave_req_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_HDR  = 2'd1,
        WR_HDR  = 2'd2,
        WR_DATA = 2'd3
    } state_t;

    state_t                 state;
    logic [ENTRY_WIDTH-1:0] hdr_q;
    logic                   hdr_is_wr_q;
    logic [LEN_WIDTH-1:0]   beat_cnt;
    logic                   last_grant_wr;
    logic                   run_en;

    logic                   grant_rd;
    logic                   grant_wr;
    logic                   beat_valid;
    logic                   beat_hs;

    // Arm grants one clock after reset release. This keeps the FIFO pops at
    // zero for the whole reset window without mixing the asynchronous reset
    // into the grant logic.
    always_ff @(posedge axi_clk or negedge ARESTn) begin
        if (!ARESTn) begin
            run_en <= 1'b0;
        end else begin
            run_en <= 1'b1;
        end
    end

    // Round-robin choice in IDLE. A tie goes to the opposite of the last grant.
    // The two grants are mutually exclusive by construction.
    always_comb begin
        grant_rd = 1'b0;
        grant_wr = 1'b0;
        if (state == IDLE && run_en) begin
            if (!bus.ar_empty && !bus.aw_empty) begin
                grant_rd = last_grant_wr;
                grant_wr = !last_grant_wr;
            end else if (!bus.ar_empty) begin
                grant_rd = 1'b1;
            end else if (!bus.aw_empty) begin
                grant_wr = 1'b1;
            end
        end
    end

    // W beats are offered only while streaming a write burst.
    always_comb begin
        beat_valid = (state == WR_DATA) && !bus.w_empty;
        beat_hs    = beat_valid && bus.dat_ready;
    end

    // Main sequencer: grant, header handshake, then the write-beat count-down.
    always_ff @(posedge axi_clk or negedge ARESTn) begin
        if (!ARESTn) begin
            state         <= IDLE;
            hdr_q         <= '0;
            hdr_is_wr_q   <= 1'b0;
            beat_cnt      <= '0;
            last_grant_wr <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_rd) begin
                        hdr_q         <= bus.ar_rd_data;
                        hdr_is_wr_q   <= 1'b0;
                        last_grant_wr <= 1'b0;
                        state         <= RD_HDR;
                    end else if (grant_wr) begin
                        hdr_q         <= bus.aw_rd_data;
                        hdr_is_wr_q   <= 1'b1;
                        last_grant_wr <= 1'b1;
                        state         <= WR_HDR;
                    end
                end
                RD_HDR: begin
                    if (bus.hdr_ready) begin
                        state <= IDLE;
                    end
                end
                WR_HDR: begin
                    if (bus.hdr_ready) begin
                        // beat_cnt counts down the remaining beats after the
                        // current one, so LEN=255 gives 256 beats with no wrap.
                        beat_cnt <= hdr_q[LEN_LSB +: LEN_WIDTH];
                        state    <= WR_DATA;
                    end
                end
                WR_DATA: begin
                    if (beat_hs) begin
                        beat_cnt <= beat_cnt - LEN_WIDTH'(1);
                        if (beat_cnt == '0) begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // FIFO pops: a header pop only on the grant cycle, a W pop only on a
    // beat handshake.
    assign bus.ar_rd_en  = grant_rd;
    assign bus.aw_rd_en  = grant_wr;
    assign bus.w_rd_en   = beat_hs;

    // Header channel, driven from the latched entry.
    assign bus.hdr_valid = (state == RD_HDR) || (state == WR_HDR);
    assign bus.hdr_is_wr = hdr_is_wr_q;
    assign bus.hdr_data  = hdr_q;

    // Data channel passes the W head through, forced to zero outside bursts.
    assign bus.dat_valid = beat_valid;
    assign bus.dat_data  = (state == WR_DATA) ? bus.w_rd_data : '0;
    assign bus.dat_last  = beat_valid && (beat_cnt == '0);

    assign bus.busy      = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_axi_slave_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_slave_req_arbiter
//  Description : Self-checking bench for axi_slave_req_arbiter. FIFOs are
//                modelled with queues. Expected header order and beat stream
//                come from a round-robin model over the queued contents.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_axi_slave_req_arbiter;

    localparam int ENTRY_WIDTH = 85;
    localparam int LEN_LSB     = 8;
    localparam int LEN_WIDTH   = 8;
    localparam int DATA_WIDTH  = 1024;

    logic axi_clk = 1'b0;
    logic ARESTn  = 1'b0;

    axi_slave_req_arbiter_if #(.ENTRY_WIDTH(ENTRY_WIDTH), .DATA_WIDTH(DATA_WIDTH)) bus ();

    axi_slave_req_arbiter #(
        .ENTRY_WIDTH(ENTRY_WIDTH),
        .LEN_LSB    (LEN_LSB),
        .LEN_WIDTH  (LEN_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) dut (
        .axi_clk(axi_clk),
        .ARESTn (ARESTn),
        .bus    (bus.master)
    );

    always #5 axi_clk = ~axi_clk;

    int total = 0;
    int bad   = 0;

    logic [ENTRY_WIDTH-1:0] ar_q[$];
    logic [ENTRY_WIDTH-1:0] aw_q[$];
    logic [DATA_WIDTH-1:0]  w_q[$];
    logic [ENTRY_WIDTH:0]   exp_hdr[$];
    logic [DATA_WIDTH:0]    exp_beat[$];
    bit                     m_last_wr = 1'b1;
    bit                     w_hide    = 1'b0;
    int                     w_pops    = 0;
    bit                     pop_ar, pop_aw, pop_w;

    function automatic logic [DATA_WIDTH-1:0] rand_data();
        logic [DATA_WIDTH-1:0] d;
        for (int i = 0; i < DATA_WIDTH/32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    function automatic logic [ENTRY_WIDTH-1:0] make_entry(input logic [4:0] id, input logic [7:0] len);
        logic [63:0] addr;
        addr = {$urandom, $urandom};
        return {id, addr, len, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 2)), 3'($urandom_range(0, 7))};
    endfunction

    // Present the queue heads on the FIFO read ports.
    task automatic refresh();
        bus.ar_empty   = (ar_q.size() == 0);
        bus.ar_rd_data = (ar_q.size() != 0) ? ar_q[0] : '0;
        bus.aw_empty   = (aw_q.size() == 0);
        bus.aw_rd_data = (aw_q.size() != 0) ? aw_q[0] : '0;
        bus.w_empty    = (w_q.size() == 0) || w_hide;
        bus.w_rd_data  = (w_q.size() != 0) ? w_q[0] : '0;
    endtask

    task automatic push_rd(input logic [4:0] id, input logic [7:0] len);
        ar_q.push_back(make_entry(id, len));
    endtask

    task automatic push_wr(input logic [4:0] id, input logic [7:0] len);
        aw_q.push_back(make_entry(id, len));
        for (int k = 0; k <= int'(len); k++) w_q.push_back(rand_data());
    endtask

    // FIFO model: pops sampled mid-cycle are applied just after the edge.
    always begin
        @(negedge axi_clk);
        pop_ar = bus.ar_rd_en;
        pop_aw = bus.aw_rd_en;
        pop_w  = bus.w_rd_en;
        @(posedge axi_clk);
        #1;
        if (pop_ar) begin
            total++;
            if (ar_q.size() == 0) begin bad++; $display("FAIL ar_underflow: popped with size=0 (required size>0)"); end
            else void'(ar_q.pop_front());
        end
        if (pop_aw) begin
            total++;
            if (aw_q.size() == 0) begin bad++; $display("FAIL aw_underflow: popped with size=0 (required size>0)"); end
            else void'(aw_q.pop_front());
        end
        if (pop_w) begin
            w_pops++;
            total++;
            if (w_q.size() == 0) begin bad++; $display("FAIL w_underflow: popped with size=0 (required size>0)"); end
            else void'(w_q.pop_front());
        end
        refresh();
    end

    task automatic apply_reset();
        @(posedge axi_clk); #2;
        ARESTn = 1'b0;
        ar_q.delete(); aw_q.delete(); w_q.delete();
        bus.hdr_ready = 1'b0; bus.dat_ready = 1'b0; w_hide = 1'b0;
        refresh();
        repeat (2) @(posedge axi_clk);
        #2 ARESTn = 1'b1;
        m_last_wr = 1'b1;
        @(posedge axi_clk); #2;
    endtask

    // Runs the DUT until everything queued has drained. The expected header
    // order and beat stream come from the round-robin rule over the queues.
    task automatic run_model(input int hdr_pct, input int dat_pct, input int hide_pct, input int budget);
        int ia, iw, ib, cyc, len;
        bit last, pick_wr, prev_hold;
        logic [ENTRY_WIDTH-1:0] e, prev_hdr;
        logic [ENTRY_WIDTH:0]   eh;
        logic [DATA_WIDTH:0]    eb;
        ia = 0; iw = 0; ib = 0; last = m_last_wr;
        while (ia < ar_q.size() || iw < aw_q.size()) begin
            if (ia < ar_q.size() && iw < aw_q.size()) pick_wr = !last;
            else pick_wr = (iw < aw_q.size());
            if (pick_wr) begin
                e = aw_q[iw]; iw++;
                exp_hdr.push_back({1'b1, e});
                len = int'(e[LEN_LSB +: LEN_WIDTH]);
                for (int k = 0; k <= len; k++) begin
                    exp_beat.push_back({(k == len), w_q[ib]});
                    ib++;
                end
            end else begin
                e = ar_q[ia]; ia++;
                exp_hdr.push_back({1'b0, e});
            end
            last = pick_wr;
        end
        m_last_wr = last;

        bus.hdr_ready = ($urandom_range(0, 99) < hdr_pct);
        bus.dat_ready = ($urandom_range(0, 99) < dat_pct);
        w_hide        = ($urandom_range(0, 99) < hide_pct);
        refresh();
        cyc = 0; prev_hold = 1'b0; prev_hdr = '0;
        forever begin
            @(negedge axi_clk);
            total++;
            if (bus.ar_rd_en && bus.aw_rd_en) begin bad++; $display("FAIL rd_en_excl: ar=%0b aw=%0b (required not both 1)", bus.ar_rd_en, bus.aw_rd_en); end
            total++;
            if (bus.hdr_valid && bus.dat_valid) begin bad++; $display("FAIL valid_excl: hdr_valid=1 dat_valid=1 (required not both 1)"); end
            total++;
            if (bus.w_rd_en !== (bus.dat_valid && bus.dat_ready)) begin bad++; $display("FAIL w_pop: w_rd_en=%0b (required %0b)", bus.w_rd_en, bus.dat_valid && bus.dat_ready); end
            if (bus.w_empty) begin
                total++;
                if (bus.dat_valid !== 1'b0) begin bad++; $display("FAIL dat_valid_empty: dat_valid=%0b (required 0)", bus.dat_valid); end
            end
            if (prev_hold) begin
                total++;
                if (bus.hdr_valid !== 1'b1 || bus.hdr_data !== prev_hdr) begin bad++; $display("FAIL hdr_hold: valid=%0b data=%h (required 1, %h)", bus.hdr_valid, bus.hdr_data, prev_hdr); end
            end
            if (bus.hdr_valid) begin
                total++;
                if (bus.ar_rd_en || bus.aw_rd_en) begin bad++; $display("FAIL pop_during_hdr: ar=%0b aw=%0b (required 0 0)", bus.ar_rd_en, bus.aw_rd_en); end
            end
            if (bus.hdr_valid && bus.hdr_ready) begin
                total++;
                if (exp_hdr.size() == 0) begin bad++; $display("FAIL extra_hdr: got %h (required none)", bus.hdr_data); end
                else begin
                    eh = exp_hdr.pop_front();
                    if ({bus.hdr_is_wr, bus.hdr_data} !== eh) begin bad++; $display("FAIL hdr: is_wr=%0b data=%h (required %0b %h)", bus.hdr_is_wr, bus.hdr_data, eh[ENTRY_WIDTH], eh[ENTRY_WIDTH-1:0]); end
                end
            end
            if (bus.dat_valid && bus.dat_ready) begin
                total++;
                if (exp_beat.size() == 0) begin bad++; $display("FAIL extra_beat: last=%0b (required none)", bus.dat_last); end
                else begin
                    eb = exp_beat.pop_front();
                    if (bus.dat_last !== eb[DATA_WIDTH]) begin bad++; $display("FAIL dat_last: %0b (required %0b)", bus.dat_last, eb[DATA_WIDTH]); end
                    if (bus.dat_data !== eb[DATA_WIDTH-1:0]) begin bad++; $display("FAIL dat_data: low word %h (required %h)", bus.dat_data[31:0], eb[31:0]); end
                end
            end
            prev_hold = bus.hdr_valid && !bus.hdr_ready;
            prev_hdr  = bus.hdr_data;
            if (exp_hdr.size() == 0 && exp_beat.size() == 0 && !bus.busy) break;
            cyc++;
            if (cyc > budget) begin
                total++; bad++;
                $display("FAIL run_timeout: hdr_left=%0d beats_left=%0d (required 0 0)", exp_hdr.size(), exp_beat.size());
                exp_hdr.delete(); exp_beat.delete();
                break;
            end
            @(posedge axi_clk); #2;
            bus.hdr_ready = ($urandom_range(0, 99) < hdr_pct);
            bus.dat_ready = ($urandom_range(0, 99) < dat_pct);
            w_hide        = ($urandom_range(0, 99) < hide_pct);
            refresh();
        end
        w_hide = 1'b0;
        refresh();
        repeat (2) begin
            @(negedge axi_clk);
            total++;
            if (bus.busy || bus.ar_rd_en || bus.aw_rd_en || bus.w_rd_en) begin
                bad++; $display("FAIL idle_after_drain: busy=%0b ar=%0b aw=%0b w=%0b (required 0 0 0 0)", bus.busy, bus.ar_rd_en, bus.aw_rd_en, bus.w_rd_en);
            end
        end
        @(posedge axi_clk); #2;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge axi_clk);
        #2;
        push_rd(5'd1, 8'd0);
        refresh();
        repeat (2) begin
            @(negedge axi_clk);
            total++;
            if ({bus.ar_rd_en, bus.aw_rd_en, bus.w_rd_en, bus.hdr_valid, bus.hdr_is_wr, bus.dat_valid, bus.dat_last, bus.busy} !== 8'd0
                || bus.hdr_data !== '0 || bus.dat_data !== '0) begin
                bad++; $display("FAIL reset_outputs: ar=%0b aw=%0b w=%0b hv=%0b wr=%0b dv=%0b dl=%0b busy=%0b hdr=%h (required all 0)",
                    bus.ar_rd_en, bus.aw_rd_en, bus.w_rd_en, bus.hdr_valid, bus.hdr_is_wr, bus.dat_valid, bus.dat_last, bus.busy, bus.hdr_data);
            end
        end
        ar_q.delete();
        refresh();
        @(posedge axi_clk); #2 ARESTn = 1'b1;
        @(negedge axi_clk);
        total++;
        if (bus.busy !== 1'b0 || bus.hdr_valid !== 1'b0) begin bad++; $display("FAIL reset_release: busy=%0b hdr_valid=%0b (required 0 0)", bus.busy, bus.hdr_valid); end
        repeat (2) @(posedge axi_clk);
        #2;
    endtask

    task automatic test_single_read();
        logic [ENTRY_WIDTH-1:0] e;
        int p0;
        e = make_entry(5'd5, 8'd3);
        ar_q.push_back(e);
        bus.hdr_ready = 1'b1;
        p0 = w_pops;
        refresh();
        @(negedge axi_clk);
        total++;
        if (bus.ar_rd_en !== 1'b1 || bus.hdr_valid !== 1'b0) begin bad++; $display("FAIL rd_grant: ar_rd_en=%0b hdr_valid=%0b (required 1 0)", bus.ar_rd_en, bus.hdr_valid); end
        @(negedge axi_clk);
        total++;
        if (bus.ar_rd_en !== 1'b0) begin bad++; $display("FAIL rd_pulse: ar_rd_en=%0b (required 0)", bus.ar_rd_en); end
        total++;
        if (bus.hdr_valid !== 1'b1 || bus.hdr_is_wr !== 1'b0 || bus.hdr_data !== e || bus.busy !== 1'b1) begin
            bad++; $display("FAIL rd_hdr: valid=%0b is_wr=%0b busy=%0b data=%h (required 1 0 1 %h)", bus.hdr_valid, bus.hdr_is_wr, bus.busy, bus.hdr_data, e);
        end
        @(negedge axi_clk);
        total++;
        if (bus.hdr_valid !== 1'b0 || bus.busy !== 1'b0 || bus.w_rd_en !== 1'b0 || w_pops != p0) begin
            bad++; $display("FAIL rd_done: valid=%0b busy=%0b w_pops=%0d (required 0 0 %0d)", bus.hdr_valid, bus.busy, w_pops, p0);
        end
        m_last_wr = 1'b0;
        @(posedge axi_clk); #2;
    endtask

    task automatic test_single_write();
        logic [ENTRY_WIDTH-1:0] e;
        logic [DATA_WIDTH-1:0]  b[4];
        int p0;
        e = make_entry(5'd7, 8'd3);
        aw_q.push_back(e);
        for (int k = 0; k < 4; k++) begin b[k] = rand_data(); w_q.push_back(b[k]); end
        bus.hdr_ready = 1'b1; bus.dat_ready = 1'b1;
        p0 = w_pops;
        refresh();
        @(negedge axi_clk);
        total++;
        if (bus.aw_rd_en !== 1'b1 || bus.ar_rd_en !== 1'b0) begin bad++; $display("FAIL wr_grant: aw=%0b ar=%0b (required 1 0)", bus.aw_rd_en, bus.ar_rd_en); end
        @(negedge axi_clk);
        total++;
        if (bus.hdr_valid !== 1'b1 || bus.hdr_is_wr !== 1'b1 || bus.hdr_data !== e) begin
            bad++; $display("FAIL wr_hdr: valid=%0b is_wr=%0b data=%h (required 1 1 %h)", bus.hdr_valid, bus.hdr_is_wr, bus.hdr_data, e);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge axi_clk);
            total++;
            if (bus.dat_valid !== 1'b1 || bus.dat_last !== (k == 3) || bus.dat_data !== b[k] || bus.hdr_valid !== 1'b0) begin
                bad++; $display("FAIL wr_beat%0d: valid=%0b last=%0b word=%h (required 1 %0b %h)", k, bus.dat_valid, bus.dat_last, bus.dat_data[31:0], (k == 3), b[k][31:0]);
            end
        end
        @(negedge axi_clk);
        total++;
        if (bus.busy !== 1'b0 || bus.dat_valid !== 1'b0 || (w_pops - p0) != 4) begin
            bad++; $display("FAIL wr_done: busy=%0b dat_valid=%0b w_pops=%0d (required 0 0 4)", bus.busy, bus.dat_valid, w_pops - p0);
        end
        m_last_wr = 1'b1;
        @(posedge axi_clk); #2;
    endtask

    task automatic test_tie_order();
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            push_rd(5'(i), 8'($urandom_range(0, 15)));
            push_wr(5'(i + 8), 8'($urandom_range(0, 3)));
        end
        refresh();
        run_model(100, 100, 0, 200);
    endtask

    task automatic test_backpressure();
        logic [ENTRY_WIDTH-1:0] e;
        int n;
        e = make_entry(5'd3, 8'd1);
        ar_q.push_back(e);
        bus.hdr_ready = 1'b0;
        refresh();
        n = 0;
        do begin @(negedge axi_clk); n++; end while (!bus.hdr_valid && n < 4);
        total++;
        if (bus.hdr_valid !== 1'b1) begin bad++; $display("FAIL bp_wait: hdr_valid=%0b (required 1)", bus.hdr_valid); end
        @(posedge axi_clk); #2;
        push_rd(5'd4, 8'd0);
        push_wr(5'd9, 8'd2);
        push_wr(5'd10, 8'd1);
        refresh();
        for (int c = 0; c < 5; c++) begin
            @(negedge axi_clk);
            total++;
            if (bus.hdr_valid !== 1'b1 || bus.hdr_data !== e || bus.hdr_is_wr !== 1'b0 || bus.ar_rd_en || bus.aw_rd_en) begin
                bad++; $display("FAIL bp_hold%0d: valid=%0b data=%h ar=%0b aw=%0b (required 1 %h 0 0)", c, bus.hdr_valid, bus.hdr_data, bus.ar_rd_en, bus.aw_rd_en, e);
            end
        end
        @(posedge axi_clk); #2 bus.hdr_ready = 1'b1;
        @(negedge axi_clk);
        total++;
        if (bus.hdr_valid !== 1'b1 || bus.hdr_data !== e) begin bad++; $display("FAIL bp_accept: valid=%0b data=%h (required 1 %h)", bus.hdr_valid, bus.hdr_data, e); end
        @(posedge axi_clk); #2;
        m_last_wr = 1'b0;
        run_model(60, 50, 40, 400);
    endtask

    task automatic test_long_burst();
        int p0;
        p0 = w_pops;
        push_wr(5'd17, 8'd255);
        refresh();
        run_model(100, 100, 0, 600);
        total++;
        if ((w_pops - p0) != 256) begin bad++; $display("FAIL long_burst_beats: %0d (required 256)", w_pops - p0); end
    endtask

    task automatic test_random();
        int na, nw;
        for (int r = 0; r < 8; r++) begin
            na = $urandom_range(0, 4);
            nw = $urandom_range(0, 4);
            if (na == 0 && nw == 0) na = 1;
            for (int i = 0; i < na; i++) push_rd(5'($urandom_range(0, 31)), 8'($urandom));
            for (int i = 0; i < nw; i++) push_wr(5'($urandom_range(0, 31)), 8'($urandom_range(0, 7)));
            refresh();
            run_model($urandom_range(30, 100), $urandom_range(30, 100), $urandom_range(0, 50), 2000);
        end
    endtask

    task automatic test_reset_mid_burst();
        int beats, n;
        push_wr(5'd21, 8'd3);
        bus.hdr_ready = 1'b1; bus.dat_ready = 1'b1;
        refresh();
        beats = 0; n = 0;
        while (beats < 2 && n < 20) begin
            @(negedge axi_clk);
            n++;
            if (bus.w_rd_en) beats++;
        end
        total++;
        if (beats != 2) begin bad++; $display("FAIL mid_burst_beats: %0d (required 2)", beats); end
        @(posedge axi_clk); #2;
        ARESTn = 1'b0;
        #1;
        total++;
        if ({bus.ar_rd_en, bus.aw_rd_en, bus.w_rd_en, bus.hdr_valid, bus.hdr_is_wr, bus.dat_valid, bus.dat_last, bus.busy} !== 8'd0
            || bus.hdr_data !== '0 || bus.dat_data !== '0) begin
            bad++; $display("FAIL mid_reset_outputs: ar=%0b aw=%0b w=%0b hv=%0b wr=%0b dv=%0b dl=%0b busy=%0b (required all 0)",
                bus.ar_rd_en, bus.aw_rd_en, bus.w_rd_en, bus.hdr_valid, bus.hdr_is_wr, bus.dat_valid, bus.dat_last, bus.busy);
        end
        ar_q.delete(); aw_q.delete(); w_q.delete();
        push_rd(5'd22, 8'd0);
        push_wr(5'd23, 8'd1);
        refresh();
        repeat (2) begin
            @(negedge axi_clk);
            total++;
            if (bus.ar_rd_en || bus.aw_rd_en || bus.busy) begin bad++; $display("FAIL in_reset_pop: ar=%0b aw=%0b busy=%0b (required 0 0 0)", bus.ar_rd_en, bus.aw_rd_en, bus.busy); end
        end
        @(posedge axi_clk); #2 ARESTn = 1'b1;
        #1;
        total++;
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL post_reset_busy: %0b (required 0)", bus.busy); end
        m_last_wr = 1'b1;
        run_model(100, 100, 0, 100);
    endtask

    initial begin
        bus.hdr_ready = 1'b0;
        bus.dat_ready = 1'b0;
        refresh();
        test_reset();
        test_single_read();
        test_single_write();
        test_tie_order();
        test_backpressure();
        test_long_burst();
        test_random();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached (required completion)");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
